// File: rtl/tick_shift_register_if.sv
// Bundle of the tick/control inputs and LED register outputs of tick_shift_register.
// master drives the controls and observes the register; slave is the register itself.
interface tick_shift_register_if #(
  parameter int unsigned WIDTH = 8
);
  logic             tick_in;
  logic             start;
  logic             pause;
  logic             stop;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             dir;
  logic             rotate;
  logic [WIDTH-1:0] q;
  logic             step_pulse;
  logic             wrap;
  logic             empty;
  logic             busy;

  modport master (
    output tick_in, start, pause, stop, load, load_data, dir, rotate,
    input  q, step_pulse, wrap, empty, busy
  );

  modport slave (
    input  tick_in, start, pause, stop, load, load_data, dir, rotate,
    output q, step_pulse, wrap, empty, busy
  );
endinterface

// File: rtl/tick_shift_register.sv
// LED shift/rotate register stepped by edges of an asynchronous slow tick, under IDLE/RUN/PAUSE
// control. Define BOUNCE_EN for ping-pong mode (internal direction register replaces dir).
module tick_shift_register #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [63:0] INIT_PATTERN = 64'h01,
  parameter bit          BOTH_EDGES   = 1'b0
) (
  input logic                  clk,
  input logic                  resetn,
  tick_shift_register_if.slave bus
);

  localparam logic [WIDTH-1:0] InitQ   = WIDTH'(INIT_PATTERN);
  localparam int unsigned      CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   prime_q, prime_d;
  logic                   hist_q, hist_d;
  logic                   strobe_q, strobe_d;
  logic                   sync_now;
  logic                   tick_edge;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       q_q, q_d;
  logic [WIDTH-1:0]       shifted;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   step_q, step_d;
  logic                   wrap_q, wrap_d;
  logic                   empty_q, empty_d;
  logic                   busy_q, busy_d;
  logic                   shift_en;
  logic                   dir_eff;
  logic                   rot_eff;

`ifdef BOUNCE_EN
  logic                   dir_q, dir_d;
  logic                   zf_q, zf_d;
  logic                   bounce;
`endif

  // Synchroniser, history flop and registered edge strobe. prime_q holds off edge detection
  // until both the synchroniser output and the history flop carry real tick_in samples.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.tick_in};
    prime_d   = {prime_q[SYNC_STAGES-1:0], 1'b1};
    sync_now  = sync_q[SYNC_STAGES-1];
    hist_d    = sync_now;
    tick_edge = BOTH_EDGES ? (sync_now ^ hist_q) : (sync_now & ~hist_q);
    strobe_d  = prime_q[SYNC_STAGES] & tick_edge;
  end

`ifdef BOUNCE_EN
  assign dir_eff = dir_q;
  assign rot_eff = bus.rotate & ~zf_q;
`else
  assign dir_eff = bus.dir;
  assign rot_eff = bus.rotate;
`endif

  // A load in the same cycle swallows the strobe entirely.
  assign shift_en = strobe_q & (state_q == StRun) & ~bus.load;

  always_comb begin
    case ({rot_eff, dir_eff})
      2'b00:   shifted = {q_q[WIDTH-2:0], 1'b0};
      2'b01:   shifted = {1'b0, q_q[WIDTH-1:1]};
      2'b10:   shifted = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      default: shifted = {q_q[0], q_q[WIDTH-1:1]};
    endcase
  end

`ifdef BOUNCE_EN
  // A bounce reverses direction and forces the following shift to zero-fill.
  always_comb begin
    dir_d  = dir_q;
    zf_d   = zf_q;
    bounce = shift_en & (dir_q ? shifted[0] : shifted[WIDTH-1]);
    if (shift_en) begin
      zf_d = 1'b0;
    end
    if (bounce) begin
      dir_d = ~dir_q;
      zf_d  = 1'b1;
    end
  end
`endif

  always_comb begin
    q_d     = q_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    empty_d = 1'b0;
    busy_d  = (state_q == StRun);
    if (bus.load) begin
      q_d   = bus.load_data;
      cnt_d = '0;
    end else if (shift_en) begin
      q_d     = shifted;
      step_d  = 1'b1;
      cnt_d   = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      empty_d = ~rot_eff & (shifted == '0);
`ifdef BOUNCE_EN
      wrap_d  = bounce;
`else
      wrap_d  = (cnt_q == CntLast);
`endif
    end
  end

  // Run control: stop beats the automatic empty stop, which beats pause, which beats start.
  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = StIdle;
    end else if (empty_d) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (bus.start) state_d = StRun;
        StRun:   if (bus.pause) state_d = StPause;
        StPause: if (bus.start) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q   <= '0;
      prime_q  <= '0;
      hist_q   <= 1'b0;
      strobe_q <= 1'b0;
      state_q  <= StIdle;
      q_q      <= InitQ;
      cnt_q    <= '0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      empty_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      prime_q  <= prime_d;
      hist_q   <= hist_d;
      strobe_q <= strobe_d;
      state_q  <= state_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      empty_q  <= empty_d;
      busy_q   <= busy_d;
    end
  end

`ifdef BOUNCE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dir_q <= 1'b0;
      zf_q  <= 1'b0;
    end else begin
      dir_q <= dir_d;
      zf_q  <= zf_d;
    end
  end
`endif

  assign bus.q          = q_q;
  assign bus.step_pulse = step_q;
  assign bus.wrap       = wrap_q;
  assign bus.empty      = empty_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/tick_shift_register.md
Name: tick_shift_register

Overview:
Consumer end of the 1 Hz toggling clock produced by the slow-clock generator. Samples the slow toggle signal in the fast `clk` domain, synchronises it and edge-detects it. Each detected edge advances a WIDTH-bit shift/rotate register, gated by a small run-control FSM. The register output drives the board LEDs.

Parameters:
WIDTH, 8, register width in bits (>= 2)
SYNC_STAGES, 2, flip-flop synchroniser depth on tick_in (>= 2)
INIT_PATTERN, 8'h01, value of q after reset; truncated/zero-extended to WIDTH
BOTH_EDGES, 0, 0 = step on rising edge of tick_in only; 1 = step on both edges

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
tick_in  in  1  slow toggling clock from the generator; treated as asynchronous
start  in  1  level/pulse; IDLE or PAUSE -> RUN
pause  in  1  RUN -> PAUSE
stop  in  1  any state -> IDLE
load  in  1  parallel load of load_data into q
load_data  in  WIDTH  parallel load value
dir  in  1  0 = shift toward MSB (left); 1 = shift toward LSB (right)
rotate  in  1  0 = shift with zero fill; 1 = circular rotate
q  out  WIDTH  register contents
step_pulse  out  1  one-clk pulse on every applied shift
wrap  out  1  one-clk pulse when step counter rolls over from WIDTH-1 to 0
empty  out  1  one-clk pulse when a zero-fill shift makes q == 0
busy  out  1  high in RUN

Behaviour:
- Clocking and reset:
  - All flops are on posedge `clk` with async clear on negedge `resetn`.
  - Reset values: q = INIT_PATTERN, step counter = 0, FSM = IDLE, synchroniser and edge flops = 0.
  - step_pulse = 0, wrap = 0, empty = 0, busy = 0.
  - Reset mid-operation aborts immediately. No edge is detected from the synchroniser's first post-reset sample.
- Edge detection:
  - tick_in passes through SYNC_STAGES flops, then one history flop.
  - edge = (sync & ~hist) when BOTH_EDGES = 0; edge = (sync ^ hist) otherwise.
  - Latency: SYNC_STAGES+1 clk from a tick_in transition to the edge strobe. q updates on the clk after the strobe.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE -> RUN on start.
  - RUN -> PAUSE on pause.
  - PAUSE -> RUN on start.
  - Any state -> IDLE on stop.
  - RUN -> IDLE automatically on the empty condition.
  - Priority: stop > pause > start. Simultaneous start and pause in RUN -> PAUSE.
- Shift rule: on an edge strobe while in RUN (and no load that cycle):
  - rotate = 0, dir = 0: q <= {q[WIDTH-2:0], 1'b0}
  - rotate = 0, dir = 1: q <= {1'b0, q[WIDTH-1:1]}
  - rotate = 1: circular equivalents of the above.
  - step_pulse asserts the same cycle q changes.
  - Edges in IDLE or PAUSE are discarded, not queued.
- Load:
  - load has priority over a shift in the same cycle. The edge is dropped, step_pulse stays 0.
  - Load is legal in any state and does not change state.
  - Load clears the step counter.
- Step counter:
  - Increments per applied shift, modulo WIDTH.
  - wrap pulses on the shift that takes it from WIDTH-1 to 0.
- Empty:
  - If a zero-fill shift produces q == 0, empty pulses with that shift and the FSM goes to IDLE on the same edge.
  - A rotate of q == 0 never asserts empty.
- dir and rotate are sampled at each shift. Changing them mid-run takes effect on the next edge.
- busy = (state == RUN), registered.

Optional Feature:
BOUNCE_EN
- Defined: ping-pong mode. Internal direction register (reset 0) replaces the dir port.
  - When a shift places a 1 in q[WIDTH-1] while moving left, the direction flips to right for subsequent shifts.
  - Symmetrically, a 1 in q[0] while moving right flips it to left.
  - A bounce forces rotate behaviour off: the next shift is zero-fill in the new direction. The dir port is ignored.
  - wrap pulses at each bounce instead of on counter rollover.
- Not defined: the dir port controls direction exactly as specified above; no internal direction register.

Test Plan:
1. Reset with WIDTH=8, start, rotate=1, dir=0, 9 rising edges of tick_in -> q steps 01,02,04,...,80,01,02. wrap pulses once, on the 8th shift. step_pulse is high 9 times.
2. Latency check, SYNC_STAGES=2: tick_in rises at an arbitrary clk phase -> q changes exactly 3 or 4 clk later. No glitch-double step.
3. rotate=0, dir=1, q=01, RUN, 1 edge -> q=00, empty pulses, busy drops the next cycle. A further edge leaves q=00.
4. load=1 with load_data=A5 coincident with an edge strobe in RUN -> q=A5, step_pulse=0, counter=0. The next edge with dir=0, rotate=1 gives q=4B.
5. pause during RUN, 3 edges, then start -> q unchanged across the 3 edges; stepping resumes on the next edge. Simultaneous stop+start -> IDLE.
6. resetn pulsed low mid-run with q=40 -> q=01, busy=0 asynchronously. tick_in held high through reset release produces no step.
